// File: rtl/fir_param_filter.sv
// -----------------------------------------------------------------------------
// fir_param_filter
//   Direct-form FIR filter with TAPS taps and runtime-loadable coefficients.
//   Samples enter a delay line only when in_valid is high. Products are
//   registered in stage 1 and their full-precision sum in stage 2, so a sample
//   accepted at edge N is reported at edge N+2. Bypass substitutes the
//   accepted sample (zero-extended) for the sum. Flush clears the data path
//   but keeps the coefficients.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active-low
//   Data_in     input sample (unsigned, DATA_W)
//   in_valid    Data_in is accepted this cycle
//   coef_we     coefficient write strobe
//   coef_addr   tap index to write; indices >= TAPS are ignored
//   coef_wdata  coefficient value (unsigned, COEF_W)
//   bypass      1 = report the sample itself instead of the filter sum
//   flush       synchronous clear of delay line, pipeline and fill state
//   Data_out    filter result (OUT_W), held while out_valid is low
//   out_valid   Data_out carries a new result this cycle
//   primed      TAPS samples accepted since reset/flush
// -----------------------------------------------------------------------------
module fir_param_filter #(
    parameter int DATA_W = 4,
    parameter int COEF_W = 3,
    parameter int TAPS   = 8,
    localparam int AW    = $clog2(TAPS),
    localparam int OUT_W = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              in_valid,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    input  logic              bypass,
    input  logic              flush,
    output logic [OUT_W-1:0]  Data_out,
    output logic              out_valid,
    output logic              primed
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CNT_W  = $clog2(TAPS + 1);

    logic [COEF_W-1:0]            coef_reg [TAPS];
    logic [DATA_W-1:0]            x_reg    [TAPS];
    logic [PROD_W-1:0]            prod_reg [TAPS];
    logic [TAPS-1:0]              coef_sel;
    logic [TAPS-1:0][PROD_W-1:0]  prod_next;
    logic [OUT_W-1:0]             sum_next;

    logic                         acc_valid_reg;
    logic                         acc_byp_reg;
    logic                         s1_valid_reg;
    logic                         s1_byp_reg;
    logic [DATA_W-1:0]            s1_x0_reg;
    logic [OUT_W-1:0]             data_out_reg;
    logic                         out_valid_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic                         primed_reg;

    // Per-tap address decode and product. An out-of-range address matches
    // no tap, so it writes nothing.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            assign coef_sel[gi]  = coef_we && (coef_addr == AW'(gi));
            assign prod_next[gi] = PROD_W'(coef_reg[gi]) * PROD_W'(x_reg[gi]);
        end
    endgenerate

    // Coefficients: reset to 1 (moving sum); untouched by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) coef_reg[k] <= COEF_W'(1);
        end else begin
            for (int k = 0; k < TAPS; k++)
                if (coef_sel[k]) coef_reg[k] <= coef_wdata;
        end
    end

    // Delay line; shifts only on an accepted sample. Flush wins over accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) x_reg[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < TAPS; k++) x_reg[k] <= '0;
        end else if (in_valid) begin
            x_reg[0] <= Data_in;
            for (int k = 1; k < TAPS; k++) x_reg[k] <= x_reg[k-1];
        end
    end

    // Stage 1 reads the delay line one edge after the accept, i.e. after the
    // shift and after any same-cycle coefficient write has landed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) prod_reg[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < TAPS; k++) prod_reg[k] <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) prod_reg[k] <= prod_next[k];
        end
    end

    always_comb begin
        sum_next = '0;
        for (int k = 0; k < TAPS; k++)
            sum_next = sum_next + OUT_W'(prod_reg[k]);
    end

    // Control pipe: accept -> stage 1 -> stage 2. The bypass choice travels
    // with its sample, and x[0] is captured in stage 1 because the delay line
    // may shift again before stage 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_valid_reg <= 1'b0;
            acc_byp_reg   <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s1_byp_reg    <= 1'b0;
            s1_x0_reg     <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            acc_valid_reg <= 1'b0;
            acc_byp_reg   <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s1_byp_reg    <= 1'b0;
            s1_x0_reg     <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            acc_valid_reg <= in_valid;
            acc_byp_reg   <= bypass;
            s1_valid_reg  <= acc_valid_reg;
            s1_byp_reg    <= acc_byp_reg;
            s1_x0_reg     <= x_reg[0];
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg)
                data_out_reg <= s1_byp_reg ? OUT_W'(s1_x0_reg) : sum_next;
        end
    end

    // Saturating fill counter; primed rises on the same edge as the
    // TAPS-th accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg    <= '0;
            primed_reg <= 1'b0;
        end else if (flush) begin
            cnt_reg    <= '0;
            primed_reg <= 1'b0;
        end else if (in_valid && cnt_reg != CNT_W'(TAPS)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(TAPS - 1)) primed_reg <= 1'b1;
        end
    end

    assign Data_out  = data_out_reg;
    assign out_valid = out_valid_reg;
    assign primed    = primed_reg;

endmodule

// File: tb/tb_fir_param_filter.sv
// -----------------------------------------------------------------------------
// tb_fir_param_filter
//   Directed bench for fir_param_filter. A reference model of the delay line,
//   coefficients and fill counter pushes the expected result of every accepted
//   sample into a scoreboard queue tagged with the cycle it is due; each cycle
//   the outputs are compared against the queue head and the held value.
// -----------------------------------------------------------------------------
module tb_fir_param_filter;

    localparam int DATA_W = 4;
    localparam int COEF_W = 3;
    localparam int TAPS   = 8;
    localparam int AW     = $clog2(TAPS);
    localparam int OUT_W  = DATA_W + COEF_W + $clog2(TAPS);

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] Data_in;
    logic              in_valid;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic              bypass;
    logic              flush;
    logic [OUT_W-1:0]  Data_out;
    logic              out_valid;
    logic              primed;

    fir_param_filter #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .Data_in   (Data_in),
        .in_valid  (in_valid),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .bypass    (bypass),
        .flush     (flush),
        .Data_out  (Data_out),
        .out_valid (out_valid),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int data;
    } sb_t;

    sb_t sb[$];
    int  mx[TAPS];
    int  mc[TAPS];
    int  mcount;
    bit  mprimed;
    int  mdout;
    int  cyc;
    int  n_assert;
    int  n_fail;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            mx[k] = 0;
            mc[k] = 1;
        end
        mcount  = 0;
        mprimed = 0;
        mdout   = 0;
        sb.delete();
    endtask

    // One clock: update the model with the inputs seen at the edge, then
    // compare the outputs on the falling edge.
    task automatic tick();
        int  acc;
        bit  expv;
        sb_t e;
        @(posedge clk);
        cyc++;
        if (reset) begin
            if (coef_we) mc[coef_addr] = int'(coef_wdata);
            if (flush) begin
                for (int k = 0; k < TAPS; k++) mx[k] = 0;
                mcount  = 0;
                mprimed = 0;
                mdout   = 0;
                sb.delete();
            end else if (in_valid) begin
                for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
                mx[0] = int'(Data_in);
                acc = 0;
                for (int k = 0; k < TAPS; k++) acc += mc[k] * mx[k];
                e.due  = cyc + 2;
                e.data = bypass ? mx[0] : acc;
                sb.push_back(e);
                if (mcount < TAPS) mcount++;
                mprimed = (mcount == TAPS);
            end
        end
        @(negedge clk);
        expv = 0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e     = sb.pop_front();
            mdout = e.data;
            expv  = 1;
        end
        chk("out_valid", int'(out_valid), int'(expv));
        chk("Data_out", int'(Data_out), mdout);
        chk("primed", int'(primed), int'(mprimed));
        $display("cyc=%0d in_valid=%0b Data_in=%0d flush=%0b bypass=%0b -> out_valid=%0b Data_out=%0d primed=%0b",
                 cyc, in_valid, Data_in, flush, bypass, out_valid, Data_out, primed);
    endtask

    task automatic accept(input int d);
        in_valid = 1'b1;
        Data_in  = DATA_W'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_all_coefs(input int v);
        for (int a = 0; a < TAPS; a++) begin
            coef_we    = 1'b1;
            coef_addr  = AW'(a);
            coef_wdata = COEF_W'(v);
            tick();
        end
        coef_we = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        cyc        = 0;
        reset      = 1'b0;
        Data_in    = '0;
        in_valid   = 1'b0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        bypass     = 1'b0;
        flush      = 1'b0;
        model_reset();

        // Reset state
        idle(3);
        reset = 1'b1;
        idle(1);

        // 1: default coefficients, single sample
        accept(5);
        idle(2);
        chk("t1_single", int'(Data_out), 5);

        // 2: constant 15 ramps to 120 and holds
        do_flush();
        for (int i = 0; i < 10; i++) accept(15);
        idle(2);
        chk("t2_hold", int'(Data_out), 120);
        chk("t2_primed", int'(primed), 1);

        // 3: wrapping ramp, accept every other cycle
        do_flush();
        for (int i = 0; i < 20; i++) begin
            accept(i % 16);
            idle(1);
        end
        idle(1);

        // 4: all coefficients 7, then c[0]=0 in the same cycle as an accept
        write_all_coefs(7);
        for (int i = 0; i < 8; i++) accept(15);
        idle(2);
        chk("t4_840", int'(Data_out), 840);
        coef_we    = 1'b1;
        coef_addr  = '0;
        coef_wdata = '0;
        accept(15);
        coef_we = 1'b0;
        idle(2);
        chk("t4_735", int'(Data_out), 735);

        // 5: flush with a simultaneous accept drops that sample
        write_all_coefs(1);
        for (int i = 0; i < 8; i++) accept(3);
        flush    = 1'b1;
        in_valid = 1'b1;
        Data_in  = 4'd9;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_primed_cleared", int'(primed), 0);
        accept(9);
        idle(2);
        chk("t5_after_flush", int'(Data_out), 9);

        // 6: bypass, then reset asserted with samples in flight
        bypass = 1'b1;
        accept(12);
        idle(2);
        chk("t6_bypass", int'(Data_out), 12);
        accept(4);
        accept(6);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_dout", int'(Data_out), 0);
        chk("t6_async_valid", int'(out_valid), 0);
        chk("t6_async_primed", int'(primed), 0);
        model_reset();
        idle(2);
        reset  = 1'b1;
        bypass = 1'b0;
        idle(4);
        accept(5);
        idle(2);
        chk("t6_coef_reset", int'(Data_out), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
